// File: rtl/writeback_stage_pipe_if.sv
// Memory-stage to writeback-stage bundle: valid/allow-in handshake, latched fields and
// the register-file write port driven back out by the writeback stage.
interface writeback_stage_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 6
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic               ms_valid;
    logic               ws_allowin;
    logic               ms_reg_en;
    logic [RADDR_W-1:0] ms_reg_waddr;
    logic               ms_mem_read;
    logic [2:0]         ms_load_type;
    logic [OFF_W-1:0]   ms_addr_off;
    logic [DATA_W-1:0]  ms_alu_result;
    logic [DATA_W-1:0]  ms_mem_rdata;
    logic               ms_double_en;
    logic [DATA_W-1:0]  ms_md_hi;
    logic [DATA_W-1:0]  ms_md_lo;
    logic               wb_valid;
    logic               wb_reg_en;
    logic [RADDR_W-1:0] wb_reg_waddr;
    logic [DATA_W-1:0]  wb_reg_wdata;
    logic               wb_busy;

    modport slave (
        input  ms_valid, ms_reg_en, ms_reg_waddr, ms_mem_read, ms_load_type, ms_addr_off,
               ms_alu_result, ms_mem_rdata, ms_double_en, ms_md_hi, ms_md_lo,
        output ws_allowin, wb_valid, wb_reg_en, wb_reg_waddr, wb_reg_wdata, wb_busy
    );

    modport master (
        output ms_valid, ms_reg_en, ms_reg_waddr, ms_mem_read, ms_load_type, ms_addr_off,
               ms_alu_result, ms_mem_rdata, ms_double_en, ms_md_hi, ms_md_lo,
        input  ws_allowin, wb_valid, wb_reg_en, wb_reg_waddr, wb_reg_wdata, wb_busy
    );
endinterface

// File: rtl/writeback_stage_pipe.sv
// Registered writeback stage: latches one instruction per cycle, extends sub-word loads and
// splits HI/LO double results into two back-to-back register writes.
module writeback_stage_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 6,
    parameter int unsigned HI_ADDR = 32,
    parameter int unsigned LO_ADDR = 33
) (
    input logic                   clk,
    input logic                   resetn,
    writeback_stage_pipe_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StSingle = 2'd1;
    localparam logic [1:0] StDblHi  = 2'd2;
    localparam logic [1:0] StDblLo  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               reg_en_q, reg_en_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic               mem_read_q, mem_read_d;
    logic [2:0]         load_type_q, load_type_d;
    logic [OFF_W-1:0]   addr_off_q, addr_off_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;

    logic               allowin;
    logic               accept;
    logic [OFF_W-1:0]   lane_off;
    logic [DATA_W-1:0]  lane;
    logic [DATA_W-1:0]  load_data;

    assign allowin = (state_q != StDblHi);
    assign accept  = bus.ms_valid && allowin;

    always_comb begin
        state_d     = state_q;
        reg_en_d    = reg_en_q;
        waddr_d     = waddr_q;
        mem_read_d  = mem_read_q;
        load_type_d = load_type_q;
        addr_off_d  = addr_off_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (state_q == StDblHi) begin
            state_d = StDblLo;
        end else if (accept) begin
            state_d = bus.ms_double_en ? StDblHi : StSingle;
        end else begin
            state_d = StEmpty;
        end
        if (accept) begin
            reg_en_d    = bus.ms_reg_en;
            waddr_d     = bus.ms_reg_waddr;
            mem_read_d  = bus.ms_mem_read;
            load_type_d = bus.ms_load_type;
            addr_off_d  = bus.ms_addr_off;
            alu_d       = bus.ms_alu_result;
            rdata_d     = bus.ms_mem_rdata;
            hi_d        = bus.ms_md_hi;
            lo_d        = bus.ms_md_lo;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StEmpty;
            reg_en_q    <= 1'b0;
            waddr_q     <= '0;
            mem_read_q  <= 1'b0;
            load_type_q <= '0;
            addr_off_q  <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            reg_en_q    <= reg_en_d;
            waddr_q     <= waddr_d;
            mem_read_q  <= mem_read_d;
            load_type_q <= load_type_d;
            addr_off_q  <= addr_off_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // Align the offset down to the access size; at DATA_W=32 the word mask clears it fully.
    always_comb begin
        case (load_type_q)
            3'd0, 3'd1: lane_off = addr_off_q;
            3'd2, 3'd3: lane_off = addr_off_q & ~OFF_W'(1);
            3'd6:       lane_off = '0;
            default:    lane_off = addr_off_q & ~OFF_W'(3);
        endcase
        lane = rdata_q >> {lane_off, 3'b000};
        case (load_type_q)
            3'd0:    load_data = DATA_W'($signed(lane[7:0]));
            3'd1:    load_data = DATA_W'(lane[7:0]);
            3'd2:    load_data = DATA_W'($signed(lane[15:0]));
            3'd3:    load_data = DATA_W'(lane[15:0]);
            3'd5:    load_data = DATA_W'(lane[31:0]);
            3'd6:    load_data = lane;
            default: load_data = DATA_W'($signed(lane[31:0]));
        endcase
    end

    always_comb begin
        bus.ws_allowin   = allowin;
        bus.wb_valid     = (state_q != StEmpty);
        bus.wb_busy      = (state_q == StDblHi);
        bus.wb_reg_en    = 1'b0;
        bus.wb_reg_waddr = waddr_q;
        bus.wb_reg_wdata = mem_read_q ? load_data : alu_q;
        case (state_q)
            StSingle: bus.wb_reg_en = reg_en_q && (waddr_q != '0);
            StDblHi: begin
                bus.wb_reg_en    = 1'b1;
                bus.wb_reg_waddr = RADDR_W'(HI_ADDR);
                bus.wb_reg_wdata = hi_q;
            end
            StDblLo: begin
                bus.wb_reg_en    = 1'b1;
                bus.wb_reg_waddr = RADDR_W'(LO_ADDR);
                bus.wb_reg_wdata = lo_q;
            end
            default: bus.wb_reg_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Scoreboard bench driving a 32-bit and a 64-bit writeback stage with identical stimulus;
// a reference model predicts each register write and a monitor compares on wb_valid.
module tb_writeback_stage_pipe;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    writeback_stage_pipe_if #(.DATA_W(32), .RADDR_W(6)) ia ();
    writeback_stage_pipe_if #(.DATA_W(64), .RADDR_W(6)) ib ();

    writeback_stage_pipe #(.DATA_W(32)) u_dut32 (.clk(clk), .resetn(resetn), .bus(ia.slave));
    writeback_stage_pipe #(.DATA_W(64)) u_dut64 (.clk(clk), .resetn(resetn), .bus(ib.slave));

    typedef struct packed {
        logic        reg_en;
        logic [5:0]  waddr;
        logic        mem_read;
        logic [2:0]  ty;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dbl;
    } txn_t;

    typedef struct packed {
        logic [5:0]  waddr;
        logic        en;
        logic        busy;
        logic [31:0] d32;
        logic [63:0] d64;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic exp_allow = 1'b1;

    // Load result from the access size and signedness rules, in plain arithmetic.
    function automatic logic [63:0] ref_load(int dw, logic [63:0] raw, logic [2:0] ty, int off);
        int size;
        int a;
        logic [63:0] v;
        logic [63:0] m;
        case (ty)
            3'd0, 3'd1: size = 1;
            3'd2, 3'd3: size = 2;
            3'd6:       size = dw / 8;
            default:    size = 4;
        endcase
        a = off % (dw / 8);
        a = a - (a % size);
        v = raw >> (8 * a);
        m = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        v = v & m;
        if ((ty == 3'd0 || ty == 3'd2 || ty == 3'd4 || ty == 3'd7) && v[8 * size - 1])
            v = v | ~m;
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic drive(input txn_t t, input logic v);
        ia.ms_valid = v;                 ib.ms_valid = v;
        ia.ms_reg_en = t.reg_en;         ib.ms_reg_en = t.reg_en;
        ia.ms_reg_waddr = t.waddr;       ib.ms_reg_waddr = t.waddr;
        ia.ms_mem_read = t.mem_read;     ib.ms_mem_read = t.mem_read;
        ia.ms_load_type = t.ty;          ib.ms_load_type = t.ty;
        ia.ms_addr_off = t.off[1:0];     ib.ms_addr_off = t.off;
        ia.ms_alu_result = t.alu[31:0];  ib.ms_alu_result = t.alu;
        ia.ms_mem_rdata = t.rdata[31:0]; ib.ms_mem_rdata = t.rdata;
        ia.ms_double_en = t.dbl;         ib.ms_double_en = t.dbl;
        ia.ms_md_hi = t.hi[31:0];        ib.ms_md_hi = t.hi;
        ia.ms_md_lo = t.lo[31:0];        ib.ms_md_lo = t.lo;
    endtask

    task automatic step(input txn_t t, input logic v, output logic acc);
        @(negedge clk);
        checks++;
        if (ia.ws_allowin !== exp_allow || ib.ws_allowin !== exp_allow) begin
            failures++;
            $display("FAIL ws_allowin: got %b/%b expected %b", ia.ws_allowin, ib.ws_allowin,
                     exp_allow);
        end
        drive(t, v);
        acc = v && exp_allow;
        exp_allow = !(acc && t.dbl);
    endtask

    task automatic idle();
        txn_t t;
        logic acc;
        t = '0;
        step(t, 1'b0, acc);
    endtask

    task automatic send(input txn_t t, input logic has_exp, input logic [31:0] e32,
                        input logic [63:0] e64);
        logic acc;
        exp_t e;
        logic [63:0] r32;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(t, 1'b1, acc);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: instruction not taken within 4 cycles");
            return;
        end
        if (t.dbl) begin
            e = '{waddr: 6'd32, en: 1'b1, busy: 1'b1, d32: t.hi[31:0], d64: t.hi};
            sb.push_back(e);
            e = '{waddr: 6'd33, en: 1'b1, busy: 1'b0, d32: t.lo[31:0], d64: t.lo};
            sb.push_back(e);
        end else begin
            r32 = ref_load(32, {32'b0, t.rdata[31:0]}, t.ty, int'(t.off));
            e.waddr = t.waddr;
            e.en    = t.reg_en && (t.waddr != 6'd0);
            e.busy  = 1'b0;
            e.d64   = t.mem_read ? ref_load(64, t.rdata, t.ty, int'(t.off)) : t.alu;
            e.d32   = t.mem_read ? r32[31:0] : t.alu[31:0];
            if (has_exp) begin
                e.d32 = e32;
                e.d64 = e64;
            end
            sb.push_back(e);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (ia.wb_valid !== 1'b0 || ia.wb_reg_en !== 1'b0 || ia.wb_reg_waddr !== '0 ||
            ia.wb_reg_wdata !== '0 || ia.wb_busy !== 1'b0 || ia.ws_allowin !== 1'b1 ||
            ib.wb_valid !== 1'b0 || ib.wb_reg_en !== 1'b0 || ib.wb_reg_waddr !== '0 ||
            ib.wb_reg_wdata !== '0 || ib.wb_busy !== 1'b0 || ib.ws_allowin !== 1'b1) begin
            failures++;
            $display("FAIL %s: got v=%b/%b en=%b/%b a=%h/%h d=%h/%h busy=%b/%b allow=%b/%b expected zeros, allowin=1",
                     name, ia.wb_valid, ib.wb_valid, ia.wb_reg_en, ib.wb_reg_en,
                     ia.wb_reg_waddr, ib.wb_reg_waddr, ia.wb_reg_wdata, ib.wb_reg_wdata,
                     ia.wb_busy, ib.wb_busy, ia.ws_allowin, ib.ws_allowin);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && (ia.wb_valid === 1'b1 || ib.wb_valid === 1'b1)) begin
            exp_t e;
            checks++;
            if (ia.wb_valid !== ib.wb_valid || sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got valid %b/%b with %0d writes expected",
                         ia.wb_valid, ib.wb_valid, sb.size());
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if (ia.wb_reg_waddr !== e.waddr || ib.wb_reg_waddr !== e.waddr ||
                    ia.wb_reg_en !== e.en || ib.wb_reg_en !== e.en ||
                    ia.wb_busy !== e.busy || ib.wb_busy !== e.busy ||
                    ia.wb_reg_wdata !== e.d32 || ib.wb_reg_wdata !== e.d64) begin
                    failures++;
                    $display("FAIL write: got a=%0d/%0d en=%b/%b busy=%b/%b d=%h/%h expected a=%0d en=%b busy=%b d=%h/%h",
                             ia.wb_reg_waddr, ib.wb_reg_waddr, ia.wb_reg_en, ib.wb_reg_en,
                             ia.wb_busy, ib.wb_busy, ia.wb_reg_wdata, ib.wb_reg_wdata,
                             e.waddr, e.en, e.busy, e.d32, e.d64);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        txn_t z;
        z = '0;
        resetn = 1'b0;
        drive(z, 1'b0);
        #3;
        check_reset("reset_initial");
        @(negedge clk);
        resetn = 1'b1;

        // Double result abandoned by a reset while the HI half is on the port.
        t = z; t.dbl = 1'b1; t.hi = 64'hAAAA_0000; t.lo = 64'h0000_5555;
        send(t, 1'b0, '0, '0);
        @(negedge clk);
        drive(z, 1'b0);
        #2 resetn = 1'b0;
        #1 check_reset("reset_mid_double");
        sb.delete();
        exp_allow = 1'b1;
        @(negedge clk);
        resetn = 1'b1;

        t = z; t.reg_en = 1'b1; t.waddr = 6'd5; t.alu = 64'h1234_5678;
        send(t, 1'b1, 32'h1234_5678, 64'h1234_5678);

        // Sub-word extraction on both widths.
        t = z; t.reg_en = 1'b1; t.waddr = 6'd7; t.mem_read = 1'b1;
        t.rdata = 64'h1234_5678_80FF_7F01;
        t.ty = 3'd0; t.off = 3'd2; send(t, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        t.ty = 3'd1; t.off = 3'd3; send(t, 1'b1, 32'h0000_0080, 64'h0000_0000_0000_0080);
        t.ty = 3'd2; t.off = 3'd1; send(t, 1'b1, 32'h0000_7F01, 64'h0000_0000_0000_7F01);
        t.ty = 3'd3; t.off = 3'd2; send(t, 1'b1, 32'h0000_80FF, 64'h0000_0000_0000_80FF);
        t.ty = 3'd4; t.off = 3'd0; send(t, 1'b1, 32'h80FF_7F01, 64'hFFFF_FFFF_80FF_7F01);
        t.ty = 3'd7; t.off = 3'd1; send(t, 1'b1, 32'h80FF_7F01, 64'hFFFF_FFFF_80FF_7F01);
        t.rdata = 64'h8000_0000_FFFF_FFFF;
        t.ty = 3'd4; t.off = 3'd4; send(t, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        t.ty = 3'd5; t.off = 3'd0; send(t, 1'b1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        t.ty = 3'd6; t.off = 3'd5; send(t, 1'b1, 32'hFFFF_FFFF, 64'h8000_0000_FFFF_FFFF);

        // Double write with the next instruction held behind it.
        t = z; t.dbl = 1'b1; t.hi = 64'hAAAA_0000; t.lo = 64'h0000_5555;
        send(t, 1'b0, '0, '0);
        t = z; t.reg_en = 1'b1; t.waddr = 6'd9; t.alu = 64'h0BAD_F00D;
        send(t, 1'b0, '0, '0);

        t = z; t.reg_en = 1'b1; t.waddr = 6'd0; t.alu = 64'hDEAD_BEEF;
        send(t, 1'b0, '0, '0);

        for (int r = 1; r <= 4; r++) begin
            t = z; t.reg_en = 1'b1; t.waddr = 6'(r); t.alu = 64'(r * 32'h1111_1111);
            send(t, 1'b0, '0, '0);
        end
        idle();
        idle();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                t.reg_en   = 1'($urandom_range(0, 1));
                t.waddr    = 6'($urandom_range(0, 63));
                t.mem_read = 1'($urandom_range(0, 1));
                t.ty       = 3'($urandom_range(0, 6));
                t.off      = 3'($urandom_range(0, 7));
                t.alu      = {$urandom, $urandom};
                t.rdata    = {$urandom, $urandom};
                t.hi       = {$urandom, $urandom};
                t.lo       = {$urandom, $urandom};
                t.dbl      = ($urandom_range(0, 5) == 0);
                send(t, 1'b0, '0, '0);
            end
        end
        repeat (4) idle();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d writes still outstanding, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_stage_pipe.md
Name: writeback_stage_pipe

Overview:
Registered, parametrised writeback stage for the 5-stage CPU. It accepts one instruction per cycle from the memory stage via a valid/allow-in handshake and latches it. It extracts and extends sub-word load data, then drives the register-file write port. Double-result (HI/LO multiply/divide) instructions are sequenced as two single-register writes on consecutive cycles, with upstream stalled for one cycle.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
RADDR_W, 6, register write-address width (GPRs plus HI/LO).
HI_ADDR, 32, register address written with the HI half of a double result.
LO_ADDR, 33, register address written with the LO half of a double result.
OFF_W, log2(DATA_W/8), byte-offset width (derived; not overridden).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
ms_valid  in  1  memory stage presents an instruction
ws_allowin  out  1  writeback stage accepts this cycle
ms_reg_en  in  1  instruction writes a register
ms_reg_waddr  in  RADDR_W  destination register
ms_mem_read  in  1  result comes from load data
ms_load_type  in  3  0 B, 1 BU, 2 H, 3 HU, 4 W, 5 WU, 6 D
ms_addr_off  in  OFF_W  low byte-address bits of the load
ms_alu_result  in  DATA_W  ALU result
ms_mem_rdata  in  DATA_W  raw, lane-aligned memory read data
ms_double_en  in  1  HI/LO double write
ms_md_hi  in  DATA_W  HI result
ms_md_lo  in  DATA_W  LO result
wb_valid  out  1  writeback stage holds a live instruction
wb_reg_en  out  1  register-file write enable
wb_reg_waddr  out  RADDR_W  register-file write address
wb_reg_wdata  out  DATA_W  register-file write data
wb_busy  out  1  second half of a double write is pending (hazard/forwarding)

Behaviour:
- Clock, reset and handshake
  - One clock.
  - Reset is asynchronous and active-low. It forces state EMPTY and clears every latched field, so all outputs read 0 and ws_allowin reads 1.
- Load handshake
  - Accept condition: ms_valid && ws_allowin.
  - On accept, all ms_* fields are latched at the rising edge. Outputs reflect the latch in the following cycle, giving 1-cycle latency.
- State machine: EMPTY, SINGLE, DBL_HI, DBL_LO
  - EMPTY: wb_valid=0 and wb_reg_en=0. Accept with double_en=0 goes to SINGLE; accept with double_en=1 goes to DBL_HI.
  - SINGLE: emits one write. Accept goes to SINGLE or DBL_HI depending on the new instruction; no accept goes to EMPTY.
  - DBL_HI: emits waddr=HI_ADDR, wdata=md_hi, wb_busy=1, ws_allowin=0. Always goes to DBL_LO next.
  - DBL_LO: emits waddr=LO_ADDR, wdata=md_lo, wb_busy=0. Accept goes to SINGLE or DBL_HI; otherwise EMPTY.
  - ws_allowin = state != DBL_HI.
- Write enable
  - wb_reg_en = wb_valid && latched reg_en && waddr != 0 (register 0 is never written).
  - In DBL_HI and DBL_LO the enable ignores the latched reg_en and is forced to 1.
- Write-data mux
  - mem_read=0: wdata = alu_result.
  - mem_read=1: extract a lane from mem_rdata. Size is 1 byte (B/BU), 2 bytes (H/HU), 4 bytes (W/WU) or DATA_W/8 bytes (D).
  - The lane offset is addr_off aligned down to the size, so misaligned low bits are ignored.
  - B/H/W sign-extend to DATA_W; BU/HU/WU zero-extend.
  - When DATA_W=32: W and WU are identical, D equals W, and type 7 behaves as W.
- Simultaneous events
  - Back-to-back accepts in SINGLE give one write per cycle with no bubble.
  - A reset during DBL_HI abandons the LO write.

Test Plan:
- Reset asserted mid-stream → within the same cycle all outputs read 0 and ws_allowin=1. After release, the first accept of ALU result 0x1234_5678 to reg 5 → next cycle wb_reg_en=1, waddr=5, wdata=0x12345678.
- DATA_W=32, mem_rdata=0x80FF_7F01 → B off=2 gives 0xFFFFFFFF; BU off=3 gives 0x00000080; H off=1 gives 0x00007F01; HU off=2 gives 0x000080FF; W gives 0x80FF7F01.
- double_en, md_hi=0xAAAA_0000, md_lo=0x0000_5555, with ms_valid held high behind it → cycle 1: waddr=32, wdata=0xAAAA0000, wb_busy=1, ws_allowin=0. Cycle 2: waddr=33, wdata=0x00005555. The next instruction is accepted in cycle 2 and writes in cycle 3.
- Write to reg 0 with reg_en=1 → wb_valid=1, wb_reg_en=0.
- Four back-to-back single instructions to regs 1–4 → four consecutive write cycles with ws_allowin held at 1 throughout. Then ms_valid=0 → next cycle wb_valid=0 (EMPTY).
- DATA_W=64, mem_rdata=0x8000_0000_FFFF_FFFF → W off=4 gives 0xFFFFFFFF80000000; WU off=0 gives 0x00000000FFFFFFFF; D gives the full word.
